// File: rtl/ddr_axis_writer.sv
// Drains 128-bit AXIS words into single-beat MIG UI writes over a wrapping frame window.
// Optional stall counter output enabled by defining DDR_WR_STALL_CNT_EN.
module ddr_axis_writer #(
  parameter int unsigned ADDR_W      = 27,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_WORDS = 38400,
  parameter int unsigned ADDR_STEP   = 8
) (
  input  logic              ui_clk,
  input  logic              ui_rst_n,
  input  logic              init_calib_complete,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [127:0]      s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [127:0]      app_wdf_data,
  output logic [15:0]       app_wdf_mask,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  output logic              frame_done,
  output logic              busy
`ifdef DDR_WR_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(BASE_ADDR + FRAME_WORDS * ADDR_STEP);

  logic              cmd_pend_q, cmd_pend_d;
  logic              data_pend_q, data_pend_d;
  logic              last_pend_q, last_pend_d;
  logic              frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] app_addr_q, app_addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [127:0]      wdf_data_q, wdf_data_d;
  logic              cmd_done, data_done, accept;
  logic [ADDR_W-1:0] addr_inc;

  assign cmd_done      = !cmd_pend_q || app_rdy;
  assign data_done     = !data_pend_q || app_wdf_rdy;
  assign s_axis_tready = init_calib_complete && cmd_done && data_done;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign addr_inc      = next_addr_q + STEP;

  always_comb begin
    cmd_pend_d   = cmd_pend_q && !app_rdy;
    data_pend_d  = data_pend_q && !app_wdf_rdy;
    last_pend_d  = last_pend_q && !(cmd_done && data_done);
    app_addr_d   = app_addr_q;
    wdf_data_d   = wdf_data_q;
    next_addr_d  = next_addr_q;
    // The last word's final handshake fires the pulse even if a new word lands on the same edge.
    frame_done_d = last_pend_q && (cmd_pend_q || data_pend_q) && cmd_done && data_done;
    if (accept) begin
      cmd_pend_d  = 1'b1;
      data_pend_d = 1'b1;
      last_pend_d = s_axis_tlast;
      app_addr_d  = next_addr_q;
      wdf_data_d  = s_axis_tdata;
      if (s_axis_tlast || addr_inc >= LIMIT) next_addr_d = BASE;
      else                                   next_addr_d = addr_inc;
    end
  end

  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      cmd_pend_q   <= 1'b0;
      data_pend_q  <= 1'b0;
      last_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      app_addr_q   <= BASE;
      next_addr_q  <= BASE;
      wdf_data_q   <= '0;
    end else begin
      cmd_pend_q   <= cmd_pend_d;
      data_pend_q  <= data_pend_d;
      last_pend_q  <= last_pend_d;
      frame_done_q <= frame_done_d;
      app_addr_q   <= app_addr_d;
      next_addr_q  <= next_addr_d;
      wdf_data_q   <= wdf_data_d;
    end
  end

  assign app_addr     = app_addr_q;
  assign app_cmd      = 3'b000;
  assign app_en       = cmd_pend_q;
  assign app_wdf_data = wdf_data_q;
  assign app_wdf_mask = '0;
  assign app_wdf_wren = data_pend_q;
  assign app_wdf_end  = data_pend_q;
  assign frame_done   = frame_done_q;
  assign busy         = cmd_pend_q || data_pend_q;

`ifdef DDR_WR_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (((cmd_pend_q && !app_rdy) || (data_pend_q && !app_wdf_rdy)) && stall_q != '1)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge ui_clk or negedge ui_rst_n) begin
    if (!ui_rst_n) stall_q <= '0;
    else           stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ddr_axis_writer.sv
// Self-checking bench for ddr_axis_writer: directed scenarios plus randomized traffic against a word-level model.
module tb_ddr_axis_writer;
  localparam int unsigned ADDR_W = 27;
  localparam int unsigned BASE   = 0;
  localparam int unsigned FW     = 4;
  localparam int unsigned STEP   = 8;

  logic              ui_clk = 1'b0;
  logic              ui_rst_n = 1'b0;
  logic              init_calib_complete = 1'b0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [127:0]      s_axis_tdata = '0;
  logic              s_axis_tlast = 1'b0;
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy = 1'b0;
  logic [127:0]      app_wdf_data;
  logic [15:0]       app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy = 1'b0;
  logic              frame_done;
  logic              busy;
`ifdef DDR_WR_STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  ddr_axis_writer #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .FRAME_WORDS(FW), .ADDR_STEP(STEP)
  ) dut (
    .ui_clk(ui_clk), .ui_rst_n(ui_rst_n), .init_calib_complete(init_calib_complete),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .frame_done(frame_done), .busy(busy)
`ifdef DDR_WR_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 ui_clk = ~ui_clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Word-level model: at most one word is outstanding, with its command and data halves retired independently.
  logic [127:0] m_data;
  int unsigned  m_addr, m_next;
  bit           m_cmd_left, m_dat_left, m_last, m_fd;
  longint unsigned m_stall;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_data = '0; m_addr = BASE; m_next = BASE;
    m_cmd_left = 0; m_dat_left = 0; m_last = 0; m_fd = 0; m_stall = 0;
  endtask

  task automatic compare();
    bit exp_rdy;
    exp_rdy = init_calib_complete && (!m_cmd_left || app_rdy) && (!m_dat_left || app_wdf_rdy);
    chk("tready", s_axis_tready, exp_rdy);
    chk("app_en", app_en, m_cmd_left);
    chk("app_addr", app_addr, m_addr);
    chk("wren", app_wdf_wren, m_dat_left);
    chk("wdf_end", app_wdf_end, m_dat_left);
    chk("wdf_data", app_wdf_data, m_data);
    chk("frame_done", frame_done, m_fd);
    chk("busy", busy, m_cmd_left || m_dat_left);
    chk("app_cmd", app_cmd, 3'b000);
    chk("wdf_mask", app_wdf_mask, 16'h0);
`ifdef DDR_WR_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, m_stall[31:0]);
`endif
  endtask

  task automatic model_step();
    bit cmd_ok, dat_ok, acc, was_out;
    cmd_ok  = !m_cmd_left || app_rdy;
    dat_ok  = !m_dat_left || app_wdf_rdy;
    acc     = s_axis_tvalid && init_calib_complete && cmd_ok && dat_ok;
    was_out = m_cmd_left || m_dat_left;
    if ((m_cmd_left && !app_rdy) || (m_dat_left && !app_wdf_rdy))
      if (m_stall < 64'hFFFF_FFFF) m_stall++;
    m_fd = m_last && was_out && cmd_ok && dat_ok;
    if (m_cmd_left && app_rdy) m_cmd_left = 0;
    if (m_dat_left && app_wdf_rdy) m_dat_left = 0;
    if (!m_cmd_left && !m_dat_left) m_last = 0;
    if (acc) begin
      m_addr = m_next; m_data = s_axis_tdata; m_last = s_axis_tlast;
      m_cmd_left = 1; m_dat_left = 1;
      if (s_axis_tlast || m_next + STEP >= BASE + FW * STEP) m_next = BASE;
      else m_next = m_next + STEP;
    end
  endtask

  // One clock cycle: drive at the falling edge, check, advance the model, return at the next falling edge.
  task automatic cyc(input bit cal, input bit v, input logic [127:0] d, input bit l,
                     input bit r, input bit wr);
    init_calib_complete = cal; s_axis_tvalid = v; s_axis_tdata = d; s_axis_tlast = l;
    app_rdy = r; app_wdf_rdy = wr;
    #1;
    compare();
    model_step();
    @(negedge ui_clk);
  endtask

  task automatic do_reset();
    ui_rst_n = 1'b0;
    s_axis_tvalid = 0; s_axis_tlast = 0; app_rdy = 0; app_wdf_rdy = 0;
    #1;
    chk("rst_app_en", app_en, 1'b0);
    chk("rst_wren", app_wdf_wren, 1'b0);
    chk("rst_addr", app_addr, BASE);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    model_reset();
    @(negedge ui_clk); @(negedge ui_clk);
    ui_rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge ui_clk);
    do_reset();
    chk("rst_wdf_data", app_wdf_data, 128'h0);

    // Calibration gate
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 128'hAA, 0, 1, 1);
      chk("cal_tready", s_axis_tready, 1'b0);
      chk("cal_app_en", app_en, 1'b0);
    end
    cyc(1, 1, 128'hAA, 0, 1, 1);
    chk("cal_first_en", app_en, 1'b1);
    chk("cal_first_addr", app_addr, 27'd0);

    // Back-to-back stream with wrap at FW=4, no frame pulse
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      logic [26:0] ea;
      ea = 27'(((i - 1) % 4) * 8);
      cyc(1, 1, 128'(i), 0, 1, 1);
      chk("stream_addr", app_addr, ea);
      chk("stream_data", app_wdf_data, 128'(i));
      chk("stream_no_fd", frame_done, 1'b0);
    end
    cyc(1, 0, '0, 0, 1, 1);

    // Data-side stall
    do_reset();
    cyc(1, 1, 128'h5, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 128'h6, 0, 1, 0);
      if (i == 0) chk("stall_en_drop", app_en, 1'b0);
    end
    chk("stall_wren_held", app_wdf_wren, 1'b1);
    chk("stall_data_held", app_wdf_data, 128'h5);
`ifdef DDR_WR_STALL_CNT_EN
    chk("stall_count5", stall_cycles, 32'd5);
`endif
    cyc(1, 0, '0, 0, 1, 1);
    chk("stall_released", app_wdf_wren, 1'b0);

    // tlast ends the frame
    do_reset();
    cyc(1, 1, 128'h11, 0, 1, 1);
    cyc(1, 1, 128'h12, 0, 1, 1);
    cyc(1, 1, 128'h13, 1, 1, 1);
    chk("last_addr", app_addr, 27'd16);
    cyc(1, 0, '0, 0, 1, 1);
    chk("fd_pulse", frame_done, 1'b1);
    cyc(1, 0, '0, 0, 1, 1);
    chk("fd_single", frame_done, 1'b0);
    cyc(1, 1, 128'h14, 0, 1, 1);
    chk("after_last_addr", app_addr, 27'd0);
    cyc(1, 0, '0, 0, 1, 1);

    // Reset while data is pending
    cyc(1, 1, 128'h21, 0, 1, 1);
    cyc(1, 0, '0, 0, 1, 0);
    chk("pre_rst_wren", app_wdf_wren, 1'b1);
    do_reset();
    cyc(1, 1, 128'h22, 0, 1, 1);
    chk("post_rst_addr", app_addr, 27'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [127:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      cyc(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1, d,
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
